axil_memory_slave: RTL and testbench
====================================

Name: axil_memory_slave

Overview:
AXI4-Lite responder wrapping a word-organised, synchronous-read block RAM. It serves AXI-Lite read and write transactions from CPU-side initiators such as the instruction fetch unit and the data memory unit. Read and write channels are independent, and addresses outside the mapped window return SLVERR. It is the memory-side endpoint used by CPU core benches and the SoC interconnect.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of word 0
MEM_DEPTH_WORDS, 4096, number of 32-bit words (power of two)
READ_WAIT_CYCLES, 2, extra read stall cycles; used only when AXIL_MEM_READ_WAIT_EN is defined

Ports:
i_Clock  in  1  clock; all logic on rising edge
i_Reset  in  1  synchronous, active-high reset
s_axil_araddr  in  32  read byte address
s_axil_arvalid  in  1  read address valid
s_axil_arready  out  1  read address accept
s_axil_rdata  out  32  read data
s_axil_rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
s_axil_rvalid  out  1  read data valid
s_axil_rready  in  1  initiator accepts read data
s_axil_awaddr  in  32  write byte address
s_axil_awvalid  in  1  write address valid
s_axil_awready  out  1  write address accept
s_axil_wdata  in  32  write data
s_axil_wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i]
s_axil_wvalid  in  1  write data valid
s_axil_wready  out  1  write data accept
s_axil_bresp  out  2  write response; same encoding as rresp
s_axil_bvalid  out  1  write response valid
s_axil_bready  in  1  initiator accepts write response

Behaviour:
- Reset is synchronous and active-high, on i_Clock.
  - While i_Reset is high, all ready and valid outputs are 0.
  - First cycle after reset: arready=1, awready=1, wready=1; rvalid=0, bvalid=0; rdata=0, rresp=0, bresp=0.
  - Both FSMs go to idle. Partially captured AW/W beats and pending responses are dropped.
  - RAM contents are retained across reset.
- Address decode:
  - Word index = (addr - BASE_ADDR) >> 2. addr[1:0] are ignored (no unaligned handling).
  - In range: BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH_WORDS.
  - Out of range: resp = 2'b10, rdata = 0, and no RAM write.
- Read FSM: R_IDLE -> R_READ -> R_RESP.
  - R_IDLE: arready=1. On arvalid&&arready, latch the address and go to R_READ.
  - R_READ: arready=0. Registered RAM read; go to R_RESP.
  - R_RESP: rvalid=1. rdata and rresp are held stable until rready. On rvalid&&rready, go to R_IDLE.
  - rvalid rises exactly 2 edges after the AR handshake edge.
  - rvalid never drops without rready. Minimum 3 cycles per read; no read overlap.
- Write FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - W_IDLE: awready=1, wready=1.
    - Both handshake in the same cycle: go to W_RESP.
    - AW only: latch awaddr, go to W_HAVE_AW.
    - W only: latch wdata/wstrb, go to W_HAVE_W.
  - W_HAVE_AW: awready=0, wready=1. On W handshake, go to W_RESP.
  - W_HAVE_W: wready=0, awready=1. On AW handshake, go to W_RESP.
  - Commit: the RAM write (byte-masked by wstrb, in-range only) occurs on the edge entering W_RESP.
  - W_RESP: bvalid=1, awready=0, wready=0. On bvalid&&bready, go to W_IDLE.
  - wstrb=0 with an in-range address: no bytes change, bresp=OKAY.
- Read/write collision: the read array access and the write commit can fall on the same edge for the same word. Read then returns the pre-write data, and the write still completes.
- Read and write FSMs progress concurrently; neither stalls the other.

Optional Feature:
AXIL_MEM_READ_WAIT_EN
- Defined: R_READ is followed by a wait-state counter of READ_WAIT_CYCLES cycles before R_RESP, so rvalid rises 2+READ_WAIT_CYCLES edges after the AR handshake. arready stays 0 throughout. A value of 0 behaves as undefined macro.
- Undefined: fixed 2-edge latency; the counter logic and READ_WAIT_CYCLES are unused.

Test Plan:
- Write 0xDEADBEEF to 0x10 with wstrb=4'hF, AW and W in the same cycle, bready=1 -> bvalid for 1 cycle, bresp=00; then read 0x10 -> rvalid 2 edges after AR, rdata=0xDEADBEEF, rresp=00.
- Send W (0x11223344, wstrb=4'b0101) 3 cycles before AW (addr 0x10, holding 0xDEADBEEF) -> wready=0 while waiting for AW; after commit, read returns 0xDE22BE44.
- Read 0x10 with rready held low for 5 cycles -> rvalid stays 1 and rdata stays stable; arready=0 until rready.
- Read and write to BASE_ADDR+4*MEM_DEPTH_WORDS -> rresp=10, rdata=0, bresp=10; a following read of 0x0 is unchanged.
- Assert i_Reset for 1 cycle while in W_HAVE_AW and R_RESP -> rvalid=0 and bvalid=0 next cycle, all readies=1; RAM word 0x10 keeps its prior value.
- With AXIL_MEM_READ_WAIT_EN and READ_WAIT_CYCLES=3 -> rvalid rises 5 edges after the AR handshake.

Source files
------------

// File: rtl/axil_memory_slave_if.sv
// AXI4-Lite bus bundle between a CPU-side initiator (master) and the memory
// responder (slave); carries the five AXI-Lite channels, no clock or reset.
interface axil_memory_slave_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_memory_slave.sv
// AXI4-Lite responder over a word-organised synchronous-read RAM; independent read and write FSMs.
// Optional read wait states are enabled by defining AXIL_MEM_READ_WAIT_EN.
module axil_memory_slave #(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_0000,
    parameter int          MEM_DEPTH_WORDS  = 4096,
    parameter int          READ_WAIT_CYCLES = 2
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,
    axil_memory_slave_if.slave        s_axil,
    output logic [1:0]                o_rd_state,
    output logic [1:0]                o_wr_state
);
    // Handshake rule on every channel: a beat transfers on a rising edge where valid and
    // ready are both high; a raised valid holds, with its payload stable, until that edge.

    localparam int          IDX_W     = $clog2(MEM_DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(MEM_DEPTH_WORDS) << 2;
    localparam int          WCNT_W    = (READ_WAIT_CYCLES > 1) ? $clog2(READ_WAIT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((READ_WAIT_CYCLES > 0) ? READ_WAIT_CYCLES - 1 : 0);
`ifdef AXIL_MEM_READ_WAIT_EN
    localparam bit WAIT_EN = (READ_WAIT_CYCLES > 0);
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_READ, R_WAIT, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;

    logic [31:0] r_mem [MEM_DEPTH_WORDS];

    function automatic logic f_in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] f_index(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    // ---------------- read channel ----------------
    rd_state_t         r_rd_state, w_rd_next;
    logic [31:0]       r_rd_addr;
    logic              r_rd_ok;
    logic [WCNT_W-1:0] r_wait_cnt;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic              w_ar_hs;

    assign w_ar_hs = s_axil.arvalid && s_axil.arready;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_rd_state <= R_IDLE;
        else         r_rd_state <= w_rd_next;
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            R_IDLE:  if (w_ar_hs) w_rd_next = R_READ;
            R_READ:  w_rd_next = WAIT_EN ? R_WAIT : R_RESP;
            R_WAIT:  if (r_wait_cnt == WAIT_LAST) w_rd_next = R_RESP;
            R_RESP:  if (s_axil.rvalid && s_axil.rready) w_rd_next = R_IDLE;
            default: w_rd_next = R_IDLE;
        endcase
    end

    // Readies and valids are forced low for as long as reset is held.
    always_comb begin
        s_axil.arready = !i_Reset && (r_rd_state == R_IDLE);
        s_axil.rvalid  = !i_Reset && (r_rd_state == R_RESP);
        s_axil.rdata   = r_rdata;
        s_axil.rresp   = r_rresp;
    end

    // The array is sampled in R_READ only, so rdata/rresp stay frozen through R_WAIT and R_RESP.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_wait_cnt <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rd_addr <= s_axil.araddr;
                r_rd_ok   <= f_in_range(s_axil.araddr);
            end
            if (r_rd_state == R_READ) begin
                r_rdata    <= r_rd_ok ? r_mem[f_index(r_rd_addr)] : 32'h0;
                r_rresp    <= r_rd_ok ? RESP_OKAY : RESP_SLVERR;
                r_wait_cnt <= '0;
            end else if (r_rd_state == R_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t   r_wr_state, w_wr_next;
    logic [31:0] r_wr_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_bresp;
    logic        w_aw_hs, w_w_hs, w_commit, w_cm_ok;
    logic [31:0] w_cm_addr, w_cm_data;
    logic [3:0]  w_cm_strb;

    assign w_aw_hs = s_axil.awvalid && s_axil.awready;
    assign w_w_hs  = s_axil.wvalid && s_axil.wready;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) r_wr_state <= W_IDLE;
        else         r_wr_state <= w_wr_next;
    end

    always_comb begin
        w_wr_next = r_wr_state;
        case (r_wr_state)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) w_wr_next = W_RESP;
                else if (w_aw_hs)      w_wr_next = W_HAVE_AW;
                else if (w_w_hs)       w_wr_next = W_HAVE_W;
            end
            W_HAVE_AW: if (w_w_hs)  w_wr_next = W_RESP;
            W_HAVE_W:  if (w_aw_hs) w_wr_next = W_RESP;
            W_RESP:    if (s_axil.bvalid && s_axil.bready) w_wr_next = W_IDLE;
            default:   w_wr_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axil.awready = !i_Reset && ((r_wr_state == W_IDLE) || (r_wr_state == W_HAVE_W));
        s_axil.wready  = !i_Reset && ((r_wr_state == W_IDLE) || (r_wr_state == W_HAVE_AW));
        s_axil.bvalid  = !i_Reset && (r_wr_state == W_RESP);
        s_axil.bresp   = r_bresp;
    end

    // The beat completing on this edge is taken straight from the bus, the other from its latch.
    assign w_commit  = (r_wr_state != W_RESP) && (w_wr_next == W_RESP);
    assign w_cm_addr = w_aw_hs ? s_axil.awaddr : r_wr_addr;
    assign w_cm_data = w_w_hs  ? s_axil.wdata  : r_wdata;
    assign w_cm_strb = w_w_hs  ? s_axil.wstrb  : r_wstrb;
    assign w_cm_ok   = f_in_range(w_cm_addr);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_aw_hs) r_wr_addr <= s_axil.awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axil.wdata;
                r_wstrb <= s_axil.wstrb;
            end
            if (w_commit) r_bresp <= w_cm_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_commit && w_cm_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_cm_strb[i]) r_mem[f_index(w_cm_addr)][8*i +: 8] <= w_cm_data[8*i +: 8];
            end
        end
    end

    assign o_rd_state = r_rd_state;
    assign o_wr_state = r_wr_state;
endmodule

// File: tb/tb_axil_memory_slave.sv
// Randomised bench for axil_memory_slave against a word-array model of the memory map.
module tb_axil_memory_slave;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 256;
    localparam int          RWC   = 3;
`ifdef AXIL_MEM_READ_WAIT_EN
    localparam int EXP_LAT = 2 + RWC;
`else
    localparam int EXP_LAT = 2;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_memory_slave_if bus ();
    logic [1:0] rd_dbg, wr_dbg;

    axil_memory_slave #(
        .BASE_ADDR        (BASE),
        .MEM_DEPTH_WORDS  (DEPTH),
        .READ_WAIT_CYCLES (RWC)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .s_axil     (bus),
        .o_rd_state (rd_dbg),
        .o_wr_state (wr_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] model_mem [DEPTH];

    function automatic bit m_in_range(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_in_range(a)) return 32'h0;
        return model_mem[m_idx(a)];
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] a);
        return m_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (!m_in_range(a)) return;
        w = model_mem[m_idx(a)];
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model_mem[m_idx(a)] = w;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input logic [1:0] exp_resp);
        bit aw_done = 0;
        bit w_done  = 0;
        int cyc     = 0;
        bus.awaddr = a;
        bus.wdata  = d;
        bus.wstrb  = s;
        while (!(aw_done && w_done) && cyc < 60) begin
            if (aw_done) check("awready_hold", 32'(bus.awready), 32'd0);
            if (w_done)  check("wready_hold", 32'(bus.wready), 32'd0);
            bus.awvalid = !aw_done && (cyc >= aw_dly);
            bus.wvalid  = !w_done && (cyc >= w_dly);
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready)   w_done  = 1;
            @(negedge clk);
            cyc++;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        if (!(aw_done && w_done)) check("write_accept_timeout", 32'(aw_done && w_done), 32'd1);
        check("bvalid_rise", 32'(bus.bvalid), 32'd1);
        repeat (b_dly) begin
            @(negedge clk);
            check("bvalid_hold", 32'(bus.bvalid), 32'd1);
        end
        check("bresp", 32'(bus.bresp), 32'(exp_resp));
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("bvalid_drop", 32'(bus.bvalid), 32'd0);
        check("aw_w_ready_back", 32'({bus.awready, bus.wready}), 32'd3);
    endtask

    task automatic axi_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                            input logic [31:0] exp_d, input logic [1:0] exp_r);
        int cyc = 0;
        int lat = 1;
        bus.araddr  = a;
        bus.arvalid = 1'b0;
        repeat (ar_dly) @(negedge clk);
        bus.arvalid = 1'b1;
        while (!bus.arready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.arready) check("ar_timeout", 32'(bus.arready), 32'd1);
        @(negedge clk);
        bus.arvalid = 1'b0;
        while (!bus.rvalid && lat < 50) begin
            check("arready_busy", 32'(bus.arready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check("r_latency", 32'(lat), 32'(EXP_LAT));
        check("rdata", bus.rdata, exp_d);
        check("rresp", 32'(bus.rresp), 32'(exp_r));
        repeat (r_dly) begin
            @(negedge clk);
            check("rvalid_hold", 32'(bus.rvalid), 32'd1);
            check("rdata_hold", bus.rdata, exp_d);
            check("arready_wait", 32'(bus.arready), 32'd0);
        end
        bus.rready = 1'b1;
        @(negedge clk);
        bus.rready = 1'b0;
        check("rvalid_drop", 32'(bus.rvalid), 32'd0);
        check("arready_back", 32'(bus.arready), 32'd1);
    endtask

    task automatic check_idle_after_reset();
        check("rst_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'd7);
        check("rst_valids", 32'({bus.rvalid, bus.bvalid}), 32'd0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_resps", 32'({bus.rresp, bus.bresp}), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] a, a2, d, old_d;
        logic [3:0]  s;

        bus.araddr = '0; bus.arvalid = 0; bus.rready = 0;
        bus.awaddr = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 0;  bus.bready = 0;

        repeat (3) @(negedge clk);
        check("in_rst_ready_valid",
              32'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_idle_after_reset();

        // fill the whole array so every later read has a known expectation
        for (int i = 0; i < DEPTH; i++) begin
            a = BASE + 32'(4 * i);
            d = $urandom;
            m_write(a, d, 4'hF);
            axi_write(a, d, 4'hF, 0, 0, 0, 2'b00);
        end

        // directed: same-cycle AW/W, then read back
        m_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2'b00);
        axi_read(32'h10, 0, 0, 32'hDEAD_BEEF, 2'b00);

        // W three cycles ahead of AW, partial strobe
        m_write(32'h10, 32'h1122_3344, 4'b0101);
        axi_write(32'h10, 32'h1122_3344, 4'b0101, 3, 0, 0, 2'b00);
        axi_read(32'h10, 0, 0, 32'hDE22_BE44, 2'b00);

        // rready held low five cycles
        axi_read(32'h10, 0, 5, 32'hDE22_BE44, 2'b00);

        // first address past the window, both directions
        axi_write(BASE + 32'(4 * DEPTH), 32'hCAFE_F00D, 4'hF, 0, 0, 0, 2'b10);
        axi_read(BASE + 32'(4 * DEPTH), 0, 0, 32'h0, 2'b10);
        axi_read(32'h0, 0, 0, m_read(32'h0), 2'b00);
        // last in-range byte address and zero strobe
        axi_write(BASE + 32'(4 * DEPTH - 1), 32'hFFFF_FFFF, 4'h0, 0, 0, 1, 2'b00);
        axi_read(BASE + 32'(4 * DEPTH - 1), 1, 0, m_read(BASE + 32'(4 * DEPTH - 1)), 2'b00);

        // same word: array read and write commit on one edge -> pre-write data
        old_d = m_read(32'h20);
        d = $urandom;
        fork
            axi_read(32'h20, 0, 0, old_d, 2'b00);
            axi_write(32'h20, d, 4'hF, 1, 1, 0, 2'b00);
        join
        m_write(32'h20, d, 4'hF);
        axi_read(32'h20, 0, 0, d, 2'b00);

        // write commits an edge before the array read -> new data
        d = $urandom;
        m_write(32'h24, d, 4'hF);
        fork
            axi_read(32'h24, 1, 0, d, 2'b00);
            axi_write(32'h24, d, 4'hF, 0, 0, 0, 2'b00);
        join

        // reset while write holds only AW and read sits in its response phase
        bus.araddr = 32'h10; bus.arvalid = 1'b1;
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        bus.wdata = 32'h0BAD_0BAD; bus.wstrb = 4'hF;
        @(negedge clk);
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        repeat (EXP_LAT - 1) @(negedge clk);
        check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
        check("pre_rst_have_aw", 32'({bus.awready, bus.wready}), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_force_low",
              32'({bus.arready, bus.awready, bus.wready, bus.rvalid, bus.bvalid}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_after_reset();
        @(negedge clk);
        axi_read(32'h10, 0, 0, m_read(32'h10), 2'b00);

        // random sequential traffic, including just-out-of-window addresses
        for (int n = 0; n < 150; n++) begin
            a = BASE + 32'($urandom_range(0, 4 * DEPTH + 63));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2), m_resp(a));
                m_write(a, d, s);
            end else begin
                axi_read(a, $urandom_range(0, 2), $urandom_range(0, 3), m_read(a), m_resp(a));
            end
        end

        // random concurrent read + write on distinct words
        for (int n = 0; n < 40; n++) begin
            a  = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            a2 = BASE + 32'(4 * (($urandom_range(1, DEPTH - 1) + m_idx(a)) % DEPTH));
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            old_d = m_read(a);
            fork
                axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), old_d, 2'b00);
                axi_write(a2, d, s, $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 2), 2'b00);
            join
            m_write(a2, d, s);
            axi_read(a2, 0, 0, m_read(a2), 2'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
